// File: rtl/analyzer_capture_write_fsm_if.sv
// Capture-side bus for the trace writer: the sample stream comes in and memory write requests
// go out. The FSM takes the master modport; the sampler/memory side takes slave.
interface analyzer_capture_write_fsm_if #(
  parameter int unsigned SAMPLE_WIDTH        = 16,
  parameter int unsigned SAMPLE_PACKET_WIDTH = 32
);
  logic                           sample_valid;
  logic [SAMPLE_WIDTH-1:0]        sample;
  logic                           write_req;
  logic                           write_allowed;
  logic [31:0]                    writeSampleNumber;
  logic [SAMPLE_PACKET_WIDTH-1:0] write_data;

  modport master (
    input  sample_valid,
    input  sample,
    input  write_allowed,
    output write_req,
    output writeSampleNumber,
    output write_data
  );

  modport slave (
    output sample_valid,
    output sample,
    output write_allowed,
    input  write_req,
    input  writeSampleNumber,
    input  write_data
  );
endinterface

// File: rtl/analyzer_capture_write_fsm.sv
// Trace capture write FSM: pre/post-trigger capture into a circular trace memory.
// Optional ANALYZER_CAPTURE_DROP_COUNT_EN adds a saturating dropped-sample counter.
module analyzer_capture_write_fsm #(
  parameter int unsigned SAMPLE_WIDTH        = 16,
  parameter int unsigned SAMPLE_PACKET_WIDTH = 32,
  parameter int unsigned MEMORY_CAPACITY     = 2**27,
  parameter int unsigned MEMORY_WORD_WIDTH   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arm,
  input  logic                      trigger,
  input  logic [31:0]               postTriggerCount,
  analyzer_capture_write_fsm_if.master bus,
  output logic                      idle,
  output logic                      overflow,
  output logic [31:0]               sampleNumber_Begin,
  output logic [31:0]               sampleNumber_End
`ifdef ANALYZER_CAPTURE_DROP_COUNT_EN
  ,
  output logic [15:0]               dropCount
`endif
);

  localparam int unsigned TsWidth     = SAMPLE_PACKET_WIDTH - SAMPLE_WIDTH;
  localparam int unsigned PacketWords = (SAMPLE_PACKET_WIDTH / 8) / MEMORY_WORD_WIDTH;
  localparam logic [31:0] MaxSampleNumber =
      32'((MEMORY_CAPACITY / MEMORY_WORD_WIDTH) / PacketWords - 1);

  typedef enum logic [1:0] {StIdle, StPre, StPost, StDrain} state_e;

  state_e                         state_q, state_d;
  logic                           write_req_q;
  logic [31:0]                    wsn_q;
  logic [SAMPLE_PACKET_WIDTH-1:0] write_data_q;
  logic                           wrapped_q;
  logic [TsWidth-1:0]             timestamp_q;
  logic [31:0]                    remaining_q;
  logic                           overflow_q;
  logic [31:0]                    begin_q, end_q;
`ifdef ANALYZER_CAPTURE_DROP_COUNT_EN
  logic [15:0]                    drop_count_q;
`endif

  logic arm_cap, capture_en, post_phase, publish;
  logic accept, drop, decrement, complete;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    arm_cap    = 1'b0;
    capture_en = 1'b0;
    post_phase = 1'b0;
    publish    = 1'b0;
    case (state_q)
      StIdle: begin
        if (arm) begin
          arm_cap = 1'b1;
          state_d = StPre;
        end
      end
      StPre: begin
        capture_en = 1'b1;
        if (trigger) state_d = StPost;
      end
      StPost: begin
        if (remaining_q != 32'd0) begin
          capture_en = 1'b1;
          post_phase = 1'b1;
        end else begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!write_req_q) begin
          publish = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    complete  = write_req_q & bus.write_allowed;
    accept    = capture_en & bus.sample_valid & (~write_req_q | bus.write_allowed);
    drop      = capture_en & bus.sample_valid & write_req_q & ~bus.write_allowed;
    // The trigger sample is taken in StPre, so it never reaches the decrement path.
    decrement = post_phase & accept;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_req_q  <= 1'b0;
      wsn_q        <= 32'd0;
      write_data_q <= '0;
      wrapped_q    <= 1'b0;
      timestamp_q  <= '0;
      remaining_q  <= 32'd0;
      overflow_q   <= 1'b0;
      begin_q      <= 32'd0;
      end_q        <= 32'd0;
`ifdef ANALYZER_CAPTURE_DROP_COUNT_EN
      drop_count_q <= 16'd0;
`endif
    end else begin
      if (state_q != StIdle) timestamp_q <= timestamp_q + TsWidth'(1);
      if (arm_cap) begin
        wsn_q       <= 32'd0;
        wrapped_q   <= 1'b0;
        overflow_q  <= 1'b0;
        timestamp_q <= '0;
        remaining_q <= postTriggerCount;
`ifdef ANALYZER_CAPTURE_DROP_COUNT_EN
        drop_count_q <= 16'd0;
`endif
      end
      if (complete) begin
        if (wsn_q == MaxSampleNumber) begin
          wsn_q     <= 32'd0;
          wrapped_q <= 1'b1;
        end else begin
          wsn_q <= wsn_q + 32'd1;
        end
      end
      if (accept) begin
        write_data_q <= {timestamp_q, bus.sample};
        write_req_q  <= 1'b1;
      end else if (complete) begin
        write_req_q <= 1'b0;
      end
      if (drop) begin
        overflow_q <= 1'b1;
`ifdef ANALYZER_CAPTURE_DROP_COUNT_EN
        if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
`endif
      end
      if (decrement) remaining_q <= remaining_q - 32'd1;
      if (publish) begin
        end_q   <= wsn_q;
        // A wrapped buffer is full: the oldest packet sits at the next write address.
        begin_q <= wrapped_q ? wsn_q : 32'd0;
      end
    end
  end

  assign bus.write_req         = write_req_q;
  assign bus.writeSampleNumber = wsn_q;
  assign bus.write_data        = write_data_q;
  assign idle                  = (state_q == StIdle);
  assign overflow              = overflow_q;
  assign sampleNumber_Begin    = begin_q;
  assign sampleNumber_End      = end_q;
`ifdef ANALYZER_CAPTURE_DROP_COUNT_EN
  assign dropCount             = drop_count_q;
`endif

endmodule
